memaccess: RTL and testbench

MEMACCESS -- requirements
Module: memaccess

---
 rtl/memaccess.sv | 148 ++++++++++++++
 tb/tb_memaccess.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/memaccess.sv
// Memory-access pipeline stage: ALU results pass through in one cycle, while loads and stores
// run a single held data-memory request with an ack timeout and a sticky error flag.
module memaccess #(
    parameter int ACK_TIMEOUT = 16,
    parameter int RD_W        = 5,
    parameter int WORD_W      = 32,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              v_i,
    output logic              stall_o,
    input  logic              wb_i,
    input  logic [RD_W-1:0]   wb_rd_name_i,
    input  logic [WORD_W-1:0] wb_rd_data_i,
    input  logic              ld_i,
    input  logic              st_i,
    input  logic [ADDR_W-1:0] maddr_i,
    input  logic [WORD_W-1:0] sdata_i,
    output logic              wb_o,
    output logic [RD_W-1:0]   wb_rd_name_o,
    output logic [WORD_W-1:0] wb_rd_data_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [WORD_W-1:0] dmem_wdata_o,
    input  logic [WORD_W-1:0] dmem_rdata_i,
    input  logic              dmem_ack_i,
    output logic              err_o
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                is_ld_q, is_ld_d;
    logic [RD_W-1:0]     name_q, name_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                wb_q, wb_d;
    logic [RD_W-1:0]     wb_name_q, wb_name_d;
    logic [WORD_W-1:0]   wb_data_q, wb_data_d;
    logic                err_q, err_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_ld_d   = is_ld_q;
        name_d    = name_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wb_d      = 1'b0;
        wb_name_d = wb_name_q;
        wb_data_d = wb_data_q;
        err_d     = err_q;

        unique case (state_q)
            IDLE: begin
                // A stray ack in IDLE falls through untouched.
                if (v_i) begin
                    if (ld_i || st_i) begin
                        state_d = ACCESS;
                        cnt_d   = '0;
                        is_ld_d = ld_i;
                        name_d  = wb_rd_name_i;
                        req_d   = 1'b1;
                        we_d    = st_i & ~ld_i;
                        addr_d  = maddr_i;
                        wdata_d = sdata_i;
                    end else begin
                        wb_d      = wb_i;
                        wb_name_d = wb_rd_name_i;
                        wb_data_d = wb_rd_data_i;
                    end
                end
            end
            ACCESS: begin
                // Ack wins over a timeout landing in the same cycle.
                if (dmem_ack_i) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    if (is_ld_q) begin
                        wb_d      = 1'b1;
                        wb_name_d = name_q;
                        wb_data_d = dmem_rdata_i;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_ld_q   <= 1'b0;
            name_q    <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wb_q      <= 1'b0;
            wb_name_q <= '0;
            wb_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_ld_q   <= is_ld_d;
            name_q    <= name_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wb_q      <= wb_d;
            wb_name_q <= wb_name_d;
            wb_data_q <= wb_data_d;
            err_q     <= err_d;
        end
    end

    assign stall_o      = (state_q == ACCESS);
    assign wb_o         = wb_q;
    assign wb_rd_name_o = wb_name_q;
    assign wb_rd_data_o = wb_data_q;
    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_memaccess.sv
// Directed bench for memaccess: a table of ALU pass-through vectors, then hand-written
// load/store/timeout/reset sequences with hand-computed expectations.
module tb_memaccess;

    logic        clk = 1'b0;
    logic        rst;
    logic        v_i, wb_i, ld_i, st_i, dmem_ack_i;
    logic [4:0]  wb_rd_name_i;
    logic [31:0] wb_rd_data_i, sdata_i, dmem_rdata_i;
    logic [15:0] maddr_i;
    logic        stall_o, wb_o, dmem_req_o, dmem_we_o, err_o;
    logic [4:0]  wb_rd_name_o;
    logic [31:0] wb_rd_data_o, dmem_wdata_o;
    logic [15:0] dmem_addr_o;

    int checks = 0;
    int errors = 0;

    memaccess #(.ACK_TIMEOUT(16), .RD_W(5), .WORD_W(32), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .v_i(v_i), .stall_o(stall_o), .wb_i(wb_i),
        .wb_rd_name_i(wb_rd_name_i), .wb_rd_data_i(wb_rd_data_i), .ld_i(ld_i), .st_i(st_i),
        .maddr_i(maddr_i), .sdata_i(sdata_i), .wb_o(wb_o), .wb_rd_name_o(wb_rd_name_o),
        .wb_rd_data_o(wb_rd_data_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_rdata_i(dmem_rdata_i),
        .dmem_ack_i(dmem_ack_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        wb;
        logic [4:0]  name;
        logic [31:0] data;
        logic        exp_wb;
    } alu_vec_t;

    alu_vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        v_i = 0; wb_i = 0; ld_i = 0; st_i = 0; dmem_ack_i = 0;
        wb_rd_name_i = '0; wb_rd_data_i = '0; maddr_i = '0; sdata_i = '0; dmem_rdata_i = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " stall"}, {31'd0, stall_o}, 0);
        check({tag, " wb"}, {31'd0, wb_o}, 0);
        check({tag, " wb_name"}, {27'd0, wb_rd_name_o}, 0);
        check({tag, " wb_data"}, wb_rd_data_o, 0);
        check({tag, " req"}, {31'd0, dmem_req_o}, 0);
        check({tag, " we"}, {31'd0, dmem_we_o}, 0);
        check({tag, " addr"}, {16'd0, dmem_addr_o}, 0);
        check({tag, " wdata"}, dmem_wdata_o, 0);
        check({tag, " err"}, {31'd0, err_o}, 0);
    endtask

    task automatic issue_mem(input logic ld, input logic st, input logic [15:0] a,
                             input logic [31:0] d, input logic [4:0] nm);
        v_i = 1; ld_i = ld; st_i = st; maddr_i = a; sdata_i = d; wb_rd_name_i = nm; wb_i = ld;
        tick();
        idle_inputs();
    endtask

    initial begin
        int stall_cnt;
        int req_cnt;

        vecs[0] = '{1'b1, 1'b1, 5'd3,  32'h0000_00A5, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 5'd4,  32'h1111_1111, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 5'd5,  32'h2222_2222, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 5'd0,  32'h0000_0000, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 5'd17, 32'hCAFE_F00D, 1'b1};

        idle_inputs();
        rst = 0;
        #3;
        check_all_zero("reset");
        #9 rst = 1;
        tick();

        // ALU pass-through vectors
        for (int i = 0; i < 6; i++) begin
            v_i = vecs[i].v; wb_i = vecs[i].wb;
            wb_rd_name_i = vecs[i].name; wb_rd_data_i = vecs[i].data;
            tick();
            check($sformatf("alu%0d wb", i), {31'd0, wb_o}, {31'd0, vecs[i].exp_wb});
            check($sformatf("alu%0d stall", i), {31'd0, stall_o}, 0);
            if (vecs[i].exp_wb) begin
                check($sformatf("alu%0d name", i), {27'd0, wb_rd_name_o}, {27'd0, vecs[i].name});
                check($sformatf("alu%0d data", i), wb_rd_data_o, vecs[i].data);
            end
        end
        idle_inputs();
        tick();
        check("alu idle wb", {31'd0, wb_o}, 0);

        // Load, ack on the 4th ACCESS cycle; an ALU op is held by EX meanwhile
        issue_mem(1, 0, 16'h0010, 32'h0, 5'd9);
        v_i = 1; wb_i = 1; wb_rd_name_i = 5'd7; wb_rd_data_i = 32'h77;
        stall_cnt = 0;
        for (int c = 1; c <= 4; c++) begin
            if (stall_o) stall_cnt++;
            check($sformatf("ld addr c%0d", c), {16'd0, dmem_addr_o}, 32'h10);
            check($sformatf("ld req c%0d", c), {31'd0, dmem_req_o}, 1);
            check($sformatf("ld we c%0d", c), {31'd0, dmem_we_o}, 0);
            check($sformatf("ld wb c%0d", c), {31'd0, wb_o}, 0);
            if (c == 4) begin
                dmem_ack_i = 1; dmem_rdata_i = 32'hDEAD_BEEF;
            end
            tick();
        end
        dmem_ack_i = 0; dmem_rdata_i = 32'h0;
        check("ld stall cycles", stall_cnt, 4);
        check("ld retire wb", {31'd0, wb_o}, 1);
        check("ld retire name", {27'd0, wb_rd_name_o}, 9);
        check("ld retire data", wb_rd_data_o, 32'hDEAD_BEEF);
        check("ld retire req", {31'd0, dmem_req_o}, 0);
        check("ld retire stall", {31'd0, stall_o}, 0);
        tick();
        idle_inputs();
        check("held alu wb", {31'd0, wb_o}, 1);
        check("held alu name", {27'd0, wb_rd_name_o}, 7);
        check("held alu data", wb_rd_data_o, 32'h77);
        check("held alu req", {31'd0, dmem_req_o}, 0);
        tick();
        check("held alu single pulse", {31'd0, wb_o}, 0);

        // Store, ack on the 2nd ACCESS cycle
        issue_mem(0, 1, 16'hFFFF, 32'h1234_5678, 5'd2);
        for (int c = 1; c <= 2; c++) begin
            check($sformatf("st we c%0d", c), {31'd0, dmem_we_o}, 1);
            check($sformatf("st addr c%0d", c), {16'd0, dmem_addr_o}, 32'hFFFF);
            check($sformatf("st wdata c%0d", c), dmem_wdata_o, 32'h1234_5678);
            check($sformatf("st req c%0d", c), {31'd0, dmem_req_o}, 1);
            if (c == 2) dmem_ack_i = 1;
            tick();
        end
        dmem_ack_i = 0;
        check("st retire wb", {31'd0, wb_o}, 0);
        check("st retire req", {31'd0, dmem_req_o}, 0);
        check("st retire stall", {31'd0, stall_o}, 0);
        tick();
        check("st after wb", {31'd0, wb_o}, 0);

        // Ack in the last allowed (16th) cycle is a success
        issue_mem(1, 0, 16'h0042, 32'h0, 5'd12);
        for (int c = 1; c < 16; c++) tick();
        check("edge req c16", {31'd0, dmem_req_o}, 1);
        dmem_ack_i = 1; dmem_rdata_i = 32'hA5A5_0001;
        tick();
        dmem_ack_i = 0;
        check("edge wb", {31'd0, wb_o}, 1);
        check("edge data", wb_rd_data_o, 32'hA5A5_0001);
        check("edge err", {31'd0, err_o}, 0);
        tick();

        // Timeout: no ack for 16 cycles
        issue_mem(1, 0, 16'h0100, 32'h0, 5'd6);
        req_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (dmem_req_o) req_cnt++;
            check($sformatf("to wb c%0d", c), {31'd0, wb_o}, 0);
            tick();
        end
        check("to req cycles", req_cnt, 16);
        check("to err", {31'd0, err_o}, 1);
        check("to stall", {31'd0, stall_o}, 0);
        v_i = 1; wb_i = 1; wb_rd_name_i = 5'd1; wb_rd_data_i = 32'h5A;
        tick();
        idle_inputs();
        check("post-to alu wb", {31'd0, wb_o}, 1);
        check("post-to alu data", wb_rd_data_o, 32'h5A);
        check("post-to err sticky", {31'd0, err_o}, 1);
        tick();

        // Reset in the 2nd ACCESS cycle, ack one cycle after release
        issue_mem(1, 0, 16'h0200, 32'h0, 5'd8);
        tick();
        #2 rst = 0;
        #1;
        check_all_zero("async rst");
        #2 rst = 1;
        tick();
        dmem_ack_i = 1; dmem_rdata_i = 32'hBAD0_BAD0;
        tick();
        dmem_ack_i = 0;
        check_all_zero("post-rst ack");
        tick();

        // Stray ack in IDLE, then ld+st acts as a load
        dmem_ack_i = 1; dmem_rdata_i = 32'h1;
        tick();
        check("stray wb", {31'd0, wb_o}, 0);
        check("stray stall", {31'd0, stall_o}, 0);
        check("stray req", {31'd0, dmem_req_o}, 0);
        v_i = 1; ld_i = 1; st_i = 1; wb_i = 1; maddr_i = 16'h0033; wb_rd_name_i = 5'd4;
        tick();
        idle_inputs();
        check("ldst req", {31'd0, dmem_req_o}, 1);
        check("ldst we", {31'd0, dmem_we_o}, 0);
        check("ldst stall", {31'd0, stall_o}, 1);
        check("ldst addr", {16'd0, dmem_addr_o}, 32'h33);
        dmem_ack_i = 1; dmem_rdata_i = 32'h0BAD_CAFE;
        tick();
        dmem_ack_i = 0;
        check("ldst wb", {31'd0, wb_o}, 1);
        check("ldst data", wb_rd_data_o, 32'h0BAD_CAFE);
        tick();
        check("ldst wb pulse", {31'd0, wb_o}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
